rng_share_ctrl: RTL and testbench

- Sequences a shared 32-bit pseudo-random generator and hands its values to up to NUM_REQ requesters.
- Arbitration is round-robin; one generator fetch is made per grant.
- Sits between the LCG generator (request-pulse in, 32-bit value out) and consumer blocks such as game/display logic.
- Guards against stale generator output: a fetch that returns the previously delivered value is retried.

---
 rtl/rng_share_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rng_share_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rng_share_ctrl.sv
// rng_share_ctrl: shares one LCG-style random generator among NUM_REQ
// requesters. Round-robin arbitration, one generator fetch per grant, and a
// bounded retry when the generator hands back the value delivered last time.
module rng_share_ctrl #(
    parameter int NUM_REQ   = 4,   // 2..8
    parameter int RNG_LAT   = 4,   // 1..15 cycles from rng_req to rng_data
    parameter int MAX_RETRY = 2    // 0..3 extra fetches on a repeated value
) (
    input  logic               clk,
    input  logic               reset,     // asynchronous, active low
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] grant,
    output logic [31:0]        data,
    output logic               valid,
    output logic               stale,
    output logic               busy,
    output logic               rng_req,
    input  logic [31:0]        rng_data
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CHECK,
        S_DELIVER
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;      // round-robin start point for the next search
    logic [PW-1:0] gidx;     // index of the current owner
    logic [31:0]   last;     // last value actually delivered
    logic [31:0]   sample;   // generator value captured at the end of WAIT
    logic [1:0]    retry;
    logic [3:0]    wcnt;

    // Round-robin search: first set req bit at or after ptr, wrapping.
    logic               pick_found;
    logic [PW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] pick_oh;

    // Round-robin winner selection over the live request vector.
    always_comb begin
        int j;
        logic [PW-1:0] cand;
        j          = 0;
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            cand = PW'(j);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    // Owner-relative views and the end-of-transaction condition.
    logic          own_req;
    logic          own_ack;
    logic          finish;
    logic          match;
    logic          retry_ok;
    logic [PW-1:0] ptr_next;

    // Decode owner request/ack, repeat detection and the next pointer.
    always_comb begin
        own_req  = req[gidx];
        own_ack  = ack[gidx];
        // Withdrawal ends any active state; ack only counts once data is out.
        // Ack together with withdrawal in DELIVER is the same release.
        finish   = (state != S_IDLE) &&
                   (!own_req || (state == S_DELIVER && valid && own_ack));
        match    = (sample == last);
        retry_ok = (retry < 2'(MAX_RETRY));
        ptr_next = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
    end

    // Main sequencer: all outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            grant   <= '0;
            data    <= '0;
            valid   <= 1'b0;
            stale   <= 1'b0;
            busy    <= 1'b0;
            rng_req <= 1'b0;
            ptr     <= '0;
            gidx    <= '0;
            last    <= '0;
            sample  <= '0;
            retry   <= '0;
            wcnt    <= '0;
        end else begin
            // rng_req is a one-cycle pulse; only the entries into FETCH raise it.
            rng_req <= 1'b0;
            if (finish) begin
                // Completed or abandoned: either way the owner loses its turn.
                // A pulse already sent to the generator is simply left behind.
                state <= S_IDLE;
                grant <= '0;
                valid <= 1'b0;
                busy  <= 1'b0;
                retry <= '0;
                ptr   <= ptr_next;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (pick_found) begin
                            grant   <= pick_oh;
                            gidx    <= pick_idx;
                            rng_req <= 1'b1;
                            busy    <= 1'b1;
                            state   <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        wcnt  <= 4'(RNG_LAT - 1);
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wcnt == 4'd0) begin
                            sample <= rng_data;
                            state  <= S_CHECK;
                        end else begin
                            wcnt <= wcnt - 4'd1;
                        end
                    end
                    S_CHECK: begin
                        if (match && retry_ok) begin
                            // Generator repeated itself; ask again. stale keeps
                            // its old value until a CHECK actually delivers.
                            retry   <= retry + 2'd1;
                            rng_req <= 1'b1;
                            state   <= S_FETCH;
                        end else begin
                            data  <= sample;
                            last  <= sample;
                            stale <= match;
                            valid <= 1'b1;
                            state <= S_DELIVER;
                        end
                    end
                    S_DELIVER: begin
                        // Hold data/grant/valid until the owner acks or leaves.
                    end
                    default: begin
                        state <= S_IDLE;
                        grant <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Directed bench for rng_share_ctrl (NUM_REQ=4, RNG_LAT=4, MAX_RETRY=2).
module tb_rng_share_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [31:0] data;
    logic        valid;
    logic        stale;
    logic        busy;
    logic        rng_req;
    logic [31:0] rng_data;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;

    rng_share_ctrl #(.NUM_REQ(4), .RNG_LAT(4), .MAX_RETRY(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .ack      (ack),
        .grant    (grant),
        .data     (data),
        .valid    (valid),
        .stale    (stale),
        .busy     (busy),
        .rng_req  (rng_req),
        .rng_data (rng_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count generator fetch pulses.
    always @(posedge clk) if (rng_req === 1'b1) pulses <= pulses + 1;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required end before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    logic [3:0] rr_exp [5];
    int n;
    int p0;

    initial begin
        rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        reset = 1'b0; req = '0; ack = '0; rng_data = '0;

        // ---- reset state ----
        tick(); tick(); tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_rngreq", 32'(rng_req), 32'h0);
        chk("rst_data",  data, 32'h0);
        chk("rst_stale", 32'(stale), 32'h0);
        reset = 1'b1;
        tick();

        // ---- single request ----
        req = 4'b0001; rng_data = 32'h0000_000D;
        p0 = pulses;
        tick();
        chk("s1_grant", 32'(grant), 32'h1);
        chk("s1_busy",  32'(busy),  32'h1);
        wait_valid(40, n);
        chk("s1_lat",   32'(n), 32'd6);
        chk("s1_data",  data, 32'h0000_000D);
        chk("s1_stale", 32'(stale), 32'h0);
        chk("s1_pulses", 32'(pulses - p0), 32'd1);
        ack = 4'b0001;
        tick();
        chk("s1_vclr", 32'(valid), 32'h0);
        chk("s1_gclr", 32'(grant), 32'h0);
        chk("s1_ptr",  32'(dut.ptr), 32'd1);
        ack = '0; req = '0;

        // ---- round robin, pointer starts at 1 ----
        req = 4'b1111;
        p0 = pulses;
        for (int k = 0; k < 5; k++) begin
            rng_data = 32'h100 + 32'(k);
            tick();
            chk("rr_grant", 32'(grant), 32'(rr_exp[k]));
            wait_valid(40, n);
            chk("rr_lat",  32'(n), 32'd6);
            chk("rr_data", data, 32'h100 + 32'(k));
            ack = rr_exp[k];
            tick();
            chk("rr_vclr", 32'(valid), 32'h0);
            ack = '0;
        end
        req = '0;
        chk("rr_pulses", 32'(pulses - p0), 32'd5);

        // ---- establish last = 0x12345678 (ptr=2) ----
        req = 4'b0100; rng_data = 32'h1234_5678;
        tick();
        chk("st0_grant", 32'(grant), 32'h4);
        wait_valid(40, n);
        chk("st0_data", data, 32'h1234_5678);
        chk("st0_stale", 32'(stale), 32'h0);
        ack = 4'b0100; tick(); ack = '0; req = '0;

        // ---- repeated value, retries exhausted ----
        req = 4'b1000;
        p0 = pulses;
        tick();
        chk("st1_grant", 32'(grant), 32'h8);
        wait_valid(80, n);
        chk("st1_lat",   32'(n), 32'd18);
        chk("st1_pulses", 32'(pulses - p0), 32'd3);
        chk("st1_data",  data, 32'h1234_5678);
        chk("st1_stale", 32'(stale), 32'h1);
        ack = 4'b1000; tick(); ack = '0; req = '0;

        // ---- repeated once, then fresh value ----
        req = 4'b0001;
        p0 = pulses;
        tick();
        chk("st2_grant", 32'(grant), 32'h1);
        for (int k = 0; k < 6; k++) tick();
        chk("st2_hold_stale", 32'(stale), 32'h1);
        chk("st2_novalid", 32'(valid), 32'h0);
        rng_data = 32'h9ABC_DEF0;
        wait_valid(40, n);
        chk("st2_lat",   32'(n), 32'd6);
        chk("st2_pulses", 32'(pulses - p0), 32'd2);
        chk("st2_data",  data, 32'h9ABC_DEF0);
        chk("st2_stale", 32'(stale), 32'h0);
        ack = 4'b0001; tick(); ack = '0; req = '0;

        // ---- withdrawal during WAIT (ptr=1) ----
        req = 4'b0100; rng_data = 32'h5555_5555;
        tick();
        chk("wd_grant", 32'(grant), 32'h4);
        tick(); tick();
        req = '0;
        tick();
        chk("wd_gclr", 32'(grant), 32'h0);
        chk("wd_busy", 32'(busy), 32'h0);
        for (int k = 0; k < 6; k++) tick();
        chk("wd_novalid", 32'(valid), 32'h0);
        chk("wd_ptr",  32'(dut.ptr), 32'd3);
        chk("wd_last", dut.last, 32'h9ABC_DEF0);

        // ---- async reset mid-DELIVER ----
        req = 4'b0001; rng_data = 32'h77;
        tick();
        chk("ar_grant", 32'(grant), 32'h1);
        wait_valid(40, n);
        chk("ar_valid", 32'(valid), 32'h1);
        #3 reset = 1'b0;
        #1;
        chk("ar_vclr", 32'(valid), 32'h0);
        chk("ar_gclr", 32'(grant), 32'h0);
        chk("ar_bclr", 32'(busy),  32'h0);
        chk("ar_ptr",  32'(dut.ptr), 32'd0);
        tick();
        reset = 1'b1; req = '0;
        tick(); tick();
        chk("ar_post_valid", 32'(valid), 32'h0);
        chk("ar_post_grant", 32'(grant), 32'h0);
        req = 4'b0010;
        tick();
        chk("ar_regrant", 32'(grant), 32'h2);
        wait_valid(40, n);
        chk("ar_data", data, 32'h77);
        ack = 4'b0010; tick(); ack = '0; req = '0;

        // ---- ack corner cases (ptr=2) ----
        req = 4'b0010; rng_data = 32'h99;
        tick();
        chk("ak_grant", 32'(grant), 32'h2);
        tick();
        ack = 4'b0010;          // early ack in WAIT is ignored
        tick();
        ack = '0;
        wait_valid(40, n);
        chk("ak_lat",  32'(n), 32'd4);
        chk("ak_data", data, 32'h99);
        ack = 4'b0001;          // ack on a non-granted bit
        tick();
        chk("ak_other_valid", 32'(valid), 32'h1);
        chk("ak_other_grant", 32'(grant), 32'h2);
        ack = 4'b0010; req = '0; // ack and withdrawal together
        tick();
        chk("ak_done_valid", 32'(valid), 32'h0);
        chk("ak_done_grant", 32'(grant), 32'h0);
        chk("ak_ptr",  32'(dut.ptr), 32'd2);
        chk("ak_last", dut.last, 32'h99);
        ack = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
